// File: rtl/capture_sequencer.sv
// Capture sequencer: arms on enable, triggers on a rising threshold crossing,
// waits out the capture window, then streams the stored waveform as framed bytes.
module capture_sequencer #(
    parameter int N_SAMPLES = 2000,
    parameter int SAMPLE_W  = 14,
    parameter int ADDR_W    = 11,
    parameter int HOLDOFF   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic [SAMPLE_W-1:0] signal,
    output logic                trig_out,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [SAMPLE_W-1:0] rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [15:0]         frame_count,
    output logic [7:0]          missed_trig
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_CAPTURE, S_HDR, S_CNT, S_HI, S_LO, S_HOLD
    } state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] prev_sample;
    logic [ADDR_W-1:0]   cap_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                crossing;
    logic                in_frame;
    logic [7:0]          byte_sel;

    assign crossing = (prev_sample < threshold) && (signal >= threshold);
    assign in_frame = (state != S_IDLE) && (state != S_ARMED);

    // Byte to load in the current readout state; rd_data is valid for rd_addr this cycle.
    always_comb begin
        byte_sel = 8'hA5;
        case (state)
            S_CNT:   byte_sel = frame_count[7:0];
            S_HI:    byte_sel = 8'(rd_data >> 8);
            S_LO:    byte_sel = rd_data[7:0];
            default: byte_sel = 8'hA5;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            prev_sample <= '0;
            cap_cnt     <= '0;
            hold_cnt    <= '0;
            trig_out    <= 1'b0;
            rd_addr     <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 16'h0000;
            missed_trig <= 8'h00;
        end else begin
            prev_sample <= signal;
            trig_out    <= 1'b0;
            if (in_frame && crossing && missed_trig != 8'hFF)
                missed_trig <= missed_trig + 8'd1;

            case (state)
                S_IDLE: if (enable) state <= S_ARMED;
                S_ARMED: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (crossing) begin
                        trig_out <= 1'b1;
                        cap_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cap_cnt == LAST_IDX) begin
                        rd_addr <= '0;
                        state   <= S_HDR;
                    end else begin
                        cap_cnt <= cap_cnt + 1'b1;
                    end
                end
                // Each byte: load on an empty cycle, hold until accepted, then
                // advance with tx_valid low so bytes are never back-to-back.
                S_HDR, S_CNT, S_HI, S_LO: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= byte_sel;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        case (state)
                            S_HDR: state <= S_CNT;
                            S_CNT: state <= S_HI;
                            S_HI:  state <= S_LO;
                            default: begin
                                if (rd_addr == LAST_IDX) begin
                                    frame_count <= frame_count + 16'd1;
                                    hold_cnt    <= '0;
                                    rd_addr     <= '0;
                                    state       <= S_HOLD;
                                end else begin
                                    rd_addr <= rd_addr + 1'b1;
                                    state   <= S_HI;
                                end
                            end
                        endcase
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        busy  <= 1'b0;
                        state <= enable ? S_ARMED : S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: scoreboard of expected bytes, monitor on negedge
// checking order, hold-while-stalled and the one-idle-cycle gap after acceptance.
module tb_capture_sequencer;
    localparam int N       = 2000;
    localparam int SW      = 14;
    localparam int AW      = 11;
    localparam int HOLDOFF = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [SW-1:0] threshold;
    logic [SW-1:0] signal;
    logic          trig_out;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic [15:0]   frame_count;
    logic [7:0]    missed_trig;

    int   n_chk = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    bit   rdy_rand = 1'b0;
    logic [7:0] exp_q[$];

    capture_sequencer #(.N_SAMPLES(N), .SAMPLE_W(SW), .ADDR_W(AW), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .threshold(threshold), .signal(signal),
        .trig_out(trig_out), .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frame_count(frame_count),
        .missed_trig(missed_trig)
    );

    always #5 clk = ~clk;

    // Preloaded capture buffer: buf[i] = i.
    assign rd_data = (int'(rd_addr) < N) ? SW'(rd_addr) : '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] fc);
        logic [SW-1:0] v;
        exp_q.push_back(8'hA5);
        exp_q.push_back(fc);
        for (int i = 0; i < N; i++) begin
            v = SW'(i);
            exp_q.push_back(8'(v >> 8));
            exp_q.push_back(v[7:0]);
        end
    endtask

    task automatic wait_frames(input int fc_exp, input int budget);
        int i;
        i = 0;
        while (frame_count != 16'(fc_exp) && i < budget) begin
            step(1);
            i++;
        end
        chk("frame_done", 32'(frame_count), 32'(fc_exp));
        chk("q_drain", 32'(exp_q.size()), 0);
    endtask

    task automatic fire(input logic [7:0] fc);
        signal = 14'h1000;
        step(1);
        chk("trig_fire", 32'(trig_out), 1);
        chk("busy_fire", 32'(busy), 1);
        push_frame(fc);
        signal = '0;
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Byte monitor
    initial begin
        bit         stall_prev;
        bit         acc_prev;
        logic [7:0] data_prev;
        logic [31:0] exp_b;
        stall_prev = 1'b0;
        acc_prev   = 1'b0;
        data_prev  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                acc_prev   = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", 32'(tx_valid), 1);
                    chk("hold_data", 32'(tx_data), 32'(data_prev));
                end
                if (acc_prev) chk("no_b2b", 32'(tx_valid), 0);
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() != 0) exp_b = 32'(exp_q.pop_front());
                    else exp_b = 32'h100;
                    chk("byte", 32'(tx_data), exp_b);
                    acc_cnt++;
                end
                stall_prev = tx_valid && !tx_ready;
                acc_prev   = tx_valid && tx_ready;
                data_prev  = tx_data;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int i;
        rst_n     = 1'b0;
        enable    = 1'b1;
        threshold = 14'h1000;
        signal    = '0;

        // 1) reset held with enable high and a ramp through the threshold
        for (int k = 0; k < 6; k++) begin
            signal = 14'h0FFD + SW'(k);
            step(1);
        end
        chk("rst_trig", 32'(trig_out), 0);
        chk("rst_addr", 32'(rd_addr), 0);
        chk("rst_txd", 32'(tx_data), 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fc", 32'(frame_count), 0);
        chk("rst_missed", 32'(missed_trig), 0);
        signal = '0;
        rst_n  = 1'b1;
        step(1);
        chk("armed_busy", 32'(busy), 0);
        step(3);
        chk("armed_no_trig", 32'(trig_out), 0);

        // 2) already above threshold: no crossing
        threshold = 14'h3FFF;
        signal    = 14'h1000;
        step(1);
        threshold = 14'h1000;
        signal    = 14'h1001;
        step(1);
        chk("above_no_trig", 32'(trig_out), 0);
        signal = 14'h0FFF;
        step(1);
        chk("below_no_trig", 32'(trig_out), 0);

        // 3) crossing 0x0FFF -> 0x1000, full frame with tx_ready always high
        fire(8'h00);
        step(1);
        chk("trig_1cyc", 32'(trig_out), 0);
        wait_frames(1, 12000);
        chk("missed_zero", 32'(missed_trig), 0);
        step(HOLDOFF - 1);
        chk("hold_busy", 32'(busy), 1);
        step(1);
        chk("hold_exit", 32'(busy), 0);

        // 4) backpressure at 30% ready
        rdy_rand = 1'b1;
        fire(8'h01);
        wait_frames(2, 30000);
        rdy_rand = 1'b0;
        step(HOLDOFF);
        chk("hold_exit2", 32'(busy), 0);

        // 5) enable dropped in CAPTURE, 3 crossings during readout
        fire(8'h02);
        step(5);
        enable = 1'b0;
        i = 0;
        while (!tx_valid && i < 3000) begin
            step(1);
            i++;
        end
        chk("readout_start", 32'(tx_valid), 1);
        for (int k = 0; k < 3; k++) begin
            signal = 14'h1000;
            step(1);
            signal = '0;
            step(1);
        end
        chk("missed_cnt", 32'(missed_trig), 3);
        wait_frames(3, 12000);
        step(HOLDOFF - 1);
        chk("hold_busy3", 32'(busy), 1);
        step(1);
        chk("idle_after_hold", 32'(busy), 0);
        signal = 14'h1000;
        step(1);
        chk("idle_no_trig", 32'(trig_out), 0);
        signal = '0;
        step(1);
        chk("idle_not_counted", 32'(missed_trig), 3);

        // ARMED with !enable and a crossing together: abort wins
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        signal = 14'h1000;
        step(1);
        chk("abort_no_trig", 32'(trig_out), 0);
        signal = '0;
        step(1);
        chk("abort_no_trig2", 32'(trig_out), 0);
        chk("abort_busy", 32'(busy), 0);

        // 6) reset in the middle of readout
        enable = 1'b1;
        step(1);
        fire(8'h03);
        base = acc_cnt;
        i = 0;
        while (!((acc_cnt - base) >= 100 && tx_valid) && i < 8000) begin
            step(1);
            i++;
        end
        chk("pre_rst_valid", 32'(tx_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_txv_async", 32'(tx_valid), 0);
        chk("rst_fc_mid", 32'(frame_count), 0);
        chk("rst_busy_mid", 32'(busy), 0);
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(1);
        fire(8'h00);
        base = acc_cnt;
        i = 0;
        while ((acc_cnt - base) < 4 && i < 3000) begin
            step(1);
            i++;
        end
        chk("restart_bytes", 32'((acc_cnt - base) >= 4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
